// File: rtl/alu_pkg.sv
// Shared constants for the ALU request arbiter: widths, ALU control codes,
// flag bit positions and the response slot state type.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_NAND = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b1100;

    // Positions inside the 3-bit {v,n,z} flag vector
    localparam int unsigned FLG_V = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_Z = 0;

    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response buffer. Captures the ALU result on accept and holds it
// until the consumer takes it; a consume and a new capture may coincide.
module alu_rsp_slot
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              rsp_rdy,
    input  logic [DATA_W-1:0] cap_data,
    input  logic [2:0]        cap_flags,
    output logic              rsp_vld,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rsp_flags,
    output logic              free
);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        flags_q;

    // Slot occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SlotEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state: a new capture always wins over a consume
    always_comb begin
        state_d = state_q;
        case (state_q)
            SlotEmpty: if (accept) state_d = SlotFull;
            SlotFull:  if (!accept && rsp_rdy) state_d = SlotEmpty;
            default:   state_d = SlotEmpty;
        endcase
    end

    // Payload is only written on accept, so it stays stable while held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            flags_q <= '0;
        end else if (accept) begin
            data_q  <= cap_data;
            flags_q <= cap_flags;
        end
    end

    assign rsp_vld   = (state_q == SlotFull);
    assign rsp_data  = data_q;
    assign rsp_flags = flags_q;
    // A held entry being consumed this cycle already frees the slot
    assign free      = !rsp_vld | rsp_rdy;

endmodule

// File: rtl/alu_req_arb.sv
// Round-robin arbiter sharing one external combinational ALU between two
// requesters, with a one-entry response buffer per port.
module alu_req_arb
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned CTRL_W = alu_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_vld,
    output logic              req0_rdy,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_vld,
    output logic              req1_rdy,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic              rsp0_vld,
    input  logic              rsp0_rdy,
    output logic [DATA_W-1:0] rsp0_data,
    output logic [2:0]        rsp0_flags,

    output logic              rsp1_vld,
    input  logic              rsp1_rdy,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [2:0]        rsp1_flags,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_v,
    input  logic              alu_n,
    input  logic              alu_z,

    output logic [CNT_W-1:0]  issue_cnt
);

    logic             ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             free0, free1;
    logic             acc0, acc1;
    logic [2:0]       alu_flags;

    // Ready never depends on the port's own valid; the ptr port wins a tie
    assign req0_rdy = free0 & (~ptr_q | ~(req1_vld & free1));
    assign req1_rdy = free1 & ( ptr_q | ~(req0_vld & free0));
    assign acc0     = req0_vld & req0_rdy;
    assign acc1     = req1_vld & req1_rdy;

    always_comb begin
        alu_flags        = '0;
        alu_flags[FLG_V] = alu_v;
        alu_flags[FLG_N] = alu_n;
        alu_flags[FLG_Z] = alu_z;
    end

    // Steer the accepted port's operands to the ALU; idle drives zeros
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (acc0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (acc1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
    end

    // Round-robin pointer flips to the other port after each grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (acc0) begin
            ptr_q <= 1'b1;
        end else if (acc1) begin
            ptr_q <= 1'b0;
        end
    end

    // Saturating count of accepted requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((acc0 | acc1) && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign issue_cnt = cnt_q;

    alu_rsp_slot #(
        .DATA_W (DATA_W)
    ) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (acc0),
        .rsp_rdy   (rsp0_rdy),
        .cap_data  (alu_res),
        .cap_flags (alu_flags),
        .rsp_vld   (rsp0_vld),
        .rsp_data  (rsp0_data),
        .rsp_flags (rsp0_flags),
        .free      (free0)
    );

    alu_rsp_slot #(
        .DATA_W (DATA_W)
    ) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (acc1),
        .rsp_rdy   (rsp1_rdy),
        .cap_data  (alu_res),
        .cap_flags (alu_flags),
        .rsp_vld   (rsp1_vld),
        .rsp_data  (rsp1_data),
        .rsp_flags (rsp1_flags),
        .free      (free1)
    );

endmodule

// File: tb/tb_alu_req_arb.sv
// Bench for alu_req_arb: directed stimulus, a transaction-level model of the
// arbiter checked every cycle, and hand-computed literal expectations.
module tb_alu_req_arb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_vld, req0_rdy, req1_vld, req1_rdy;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_vld, rsp0_rdy, rsp1_vld, rsp1_rdy;
    logic [15:0] rsp0_data, rsp1_data;
    logic [2:0]  rsp0_flags, rsp1_flags;
    logic [15:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_ctrl;
    logic        alu_v, alu_n, alu_z;
    logic [15:0] issue_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_req_arb #(
        .DATA_W (16),
        .CTRL_W (4),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_vld   (req0_vld),
        .req0_rdy   (req0_rdy),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req1_vld   (req1_vld),
        .req1_rdy   (req1_rdy),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .rsp0_vld   (rsp0_vld),
        .rsp0_rdy   (rsp0_rdy),
        .rsp0_data  (rsp0_data),
        .rsp0_flags (rsp0_flags),
        .rsp1_vld   (rsp1_vld),
        .rsp1_rdy   (rsp1_rdy),
        .rsp1_data  (rsp1_data),
        .rsp1_flags (rsp1_flags),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_res    (alu_res),
        .alu_v      (alu_v),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .issue_cnt  (issue_cnt)
    );

    // Reference ALU, returns {v,n,z,result}; v on SLL marks a sign change
    function automatic logic [18:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] c);
        logic [15:0] r;
        logic        v;
        v = 1'b0;
        case (c)
            ALU_XOR:  r = a ^ b;
            ALU_NAND: r = ~(a & b);
            ALU_SLL:  begin r = a << b[3:0]; v = a[15] ^ r[15]; end
            default:  r = 16'h0000;
        endcase
        return {v, r[15], (r == 16'h0000), r};
    endfunction

    // The external ALU sitting beside the arbiter
    always_comb {alu_v, alu_n, alu_z, alu_res} = alu_fn(alu_a, alu_b, alu_ctrl);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state: per-port held response, fairness pointer, accept count
    logic        m_held [2];
    logic [15:0] m_data [2];
    logic [2:0]  m_flags [2];
    logic        m_ptr;
    int          m_cnt;

    logic        e_free0, e_free1, e_want0, e_want1;
    logic        e_rdy0, e_rdy1, e_acc0, e_acc1;
    logic [15:0] e_alu_a, e_alu_b, e_cnt;
    logic [3:0]  e_alu_ctrl;

    // Expected grant decision: a port may take the ALU if its slot can accept
    // and the other port is not a contender holding the turn
    always_comb begin
        e_free0 = !m_held[0] || rsp0_rdy;
        e_free1 = !m_held[1] || rsp1_rdy;
        e_want0 = req0_vld && e_free0;
        e_want1 = req1_vld && e_free1;
        e_rdy0  = e_free0 && !(e_want1 && m_ptr == 1'b1);
        e_rdy1  = e_free1 && !(e_want0 && m_ptr == 1'b0);
        e_acc0  = req0_vld && e_rdy0;
        e_acc1  = req1_vld && e_rdy1;
        e_alu_a = 16'h0; e_alu_b = 16'h0; e_alu_ctrl = 4'h0;
        if (e_acc0) begin
            e_alu_a = req0_a; e_alu_b = req0_b; e_alu_ctrl = req0_ctrl;
        end else if (e_acc1) begin
            e_alu_a = req1_a; e_alu_b = req1_b; e_alu_ctrl = req1_ctrl;
        end
        e_cnt = (m_cnt >= 65535) ? 16'hFFFF : m_cnt[15:0];
    end

    // Model transaction update
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_held[0] <= 1'b0; m_held[1] <= 1'b0;
            m_data[0] <= '0;   m_data[1] <= '0;
            m_flags[0] <= '0;  m_flags[1] <= '0;
            m_ptr <= 1'b0;
            m_cnt <= 0;
        end else begin
            if (e_acc0) begin
                m_held[0] <= 1'b1;
                {m_flags[0], m_data[0]} <= alu_fn(req0_a, req0_b, req0_ctrl);
            end else if (rsp0_rdy) begin
                m_held[0] <= 1'b0;
            end
            if (e_acc1) begin
                m_held[1] <= 1'b1;
                {m_flags[1], m_data[1]} <= alu_fn(req1_a, req1_b, req1_ctrl);
            end else if (rsp1_rdy) begin
                m_held[1] <= 1'b0;
            end
            if (e_acc0) m_ptr <= 1'b1;
            else if (e_acc1) m_ptr <= 1'b0;
            if (e_acc0 || e_acc1) m_cnt <= m_cnt + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("req0_rdy", 32'(req0_rdy), 32'(e_rdy0));
            check("req1_rdy", 32'(req1_rdy), 32'(e_rdy1));
            check("one_accept", 32'(req0_vld & req0_rdy & req1_vld & req1_rdy), 32'd0);
            check("alu_a", 32'(alu_a), 32'(e_alu_a));
            check("alu_b", 32'(alu_b), 32'(e_alu_b));
            check("alu_ctrl", 32'(alu_ctrl), 32'(e_alu_ctrl));
            check("rsp0_vld", 32'(rsp0_vld), 32'(m_held[0]));
            check("rsp1_vld", 32'(rsp1_vld), 32'(m_held[1]));
            check("rsp0_data", 32'(rsp0_data), 32'(m_data[0]));
            check("rsp1_data", 32'(rsp1_data), 32'(m_data[1]));
            check("rsp0_flags", 32'(rsp0_flags), 32'(m_flags[0]));
            check("rsp1_flags", 32'(rsp1_flags), 32'(m_flags[1]));
            check("issue_cnt", 32'(issue_cnt), 32'(e_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req0_vld = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0;
        req1_vld = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
        rsp0_rdy = 0; rsp1_rdy = 0;
        #12;
        check("rst_rsp0_vld", 32'(rsp0_vld), 32'd0);
        check("rst_rsp1_vld", 32'(rsp1_vld), 32'd0);
        check("rst_cnt", 32'(issue_cnt), 32'd0);
        check("rst_rsp0_data", 32'(rsp0_data), 32'd0);
        check("rst_rsp1_flags", 32'(rsp1_flags), 32'd0);
        rst_n = 1'b1;
        step();

        // Port 0 alone: XOR
        req0_vld = 1; req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_ctrl = ALU_XOR;
        #2 check("t1_rdy0", 32'(req0_rdy), 32'd1);
        step();
        req0_vld = 0;
        #2;
        check("t1_vld0", 32'(rsp0_vld), 32'd1);
        check("t1_data0", 32'(rsp0_data), 32'h0FF0);
        check("t1_flags0", 32'(rsp0_flags), 32'b000);
        check("t1_cnt", 32'(issue_cnt), 32'd1);
        rsp0_rdy = 1;
        step();
        rsp0_rdy = 0;

        // Port 1 alone: NAND gives zero
        req1_vld = 1; req1_a = 16'hFFFF; req1_b = 16'hFFFF; req1_ctrl = ALU_NAND;
        #2 check("t2_rdy1", 32'(req1_rdy), 32'd1);
        step();
        req1_vld = 0;
        #2;
        check("t2_vld1", 32'(rsp1_vld), 32'd1);
        check("t2_data1", 32'(rsp1_data), 32'h0000);
        check("t2_flags1", 32'(rsp1_flags), 32'b001);
        check("t2_vld0", 32'(rsp0_vld), 32'd0);
        rsp1_rdy = 1;
        step();

        // Both always valid, consumers always ready: grants alternate 0,1,0,1
        rsp0_rdy = 1;
        req0_vld = 1; req0_a = 16'h8001; req0_b = 16'h0001; req0_ctrl = ALU_SLL;
        req1_vld = 1; req1_a = 16'hAAAA; req1_b = 16'h5555; req1_ctrl = ALU_XOR;
        for (int k = 0; k < 4; k++) begin
            #2;
            check("t3_rdy0", 32'(req0_rdy), 32'((k % 2) == 0));
            check("t3_rdy1", 32'(req1_rdy), 32'((k % 2) == 1));
            if (k == 1) begin
                check("t3_data0", 32'(rsp0_data), 32'h0002);
                check("t3_flags0", 32'(rsp0_flags), 32'b100);
            end
            if (k == 2) begin
                check("t3_data1", 32'(rsp1_data), 32'hFFFF);
                check("t3_flags1", 32'(rsp1_flags), 32'b010);
            end
            step();
        end
        req1_vld = 0;
        #2 check("t3_rdy0_last", 32'(req0_rdy), 32'd1);
        step();

        // Port 0 response held: port 1 owns the ALU until port 0 is drained
        rsp0_rdy = 0;
        req0_a = 16'h1234; req0_b = 16'h00FF; req0_ctrl = ALU_XOR;
        req1_vld = 1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("t4_rdy0", 32'(req0_rdy), 32'd0);
            check("t4_rdy1", 32'(req1_rdy), 32'd1);
            check("t4_hold0", 32'(rsp0_data), 32'h0002);
            step();
        end
        rsp0_rdy = 1;
        #2;
        check("t4_reacc0", 32'(req0_rdy), 32'd1);
        check("t4_wait1", 32'(req1_rdy), 32'd0);
        step();
        rsp0_rdy = 0;
        #2;
        check("t4_new0", 32'(rsp0_data), 32'h12CB);
        check("t4_newvld0", 32'(rsp0_vld), 32'd1);

        // Fill both slots then reset asynchronously
        req0_vld = 0;
        rsp1_rdy = 0;
        step();
        req1_vld = 0;
        #2;
        check("t5_full0", 32'(rsp0_vld), 32'd1);
        check("t5_full1", 32'(rsp1_vld), 32'd1);
        rst_n = 0;
        #1;
        check("t5_rst_vld0", 32'(rsp0_vld), 32'd0);
        check("t5_rst_vld1", 32'(rsp1_vld), 32'd0);
        check("t5_rst_cnt", 32'(issue_cnt), 32'd0);
        step();
        #2 rst_n = 1;
        rsp0_rdy = 1; rsp1_rdy = 1;
        req0_vld = 1; req1_vld = 1;
        #1;
        check("t5_tie_rdy0", 32'(req0_rdy), 32'd1);
        check("t5_tie_rdy1", 32'(req1_rdy), 32'd0);

        // Counter saturation: one accept per cycle well past 0xFFFF
        for (int k = 0; k < 65540; k++) step();
        #2 check("t6_sat", 32'(issue_cnt), 32'h0000FFFF);
        step();
        #2 check("t6_sat_hold", 32'(issue_cnt), 32'h0000FFFF);
        req0_vld = 0; req1_vld = 0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
